// File: rtl/store_unit_gen_pkg.sv
// Shared types and helpers for the store/AMO front end.
// Holds AMO encodings, store sizes, FSM states, byte-enable and data-align helpers.
package store_unit_gen_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_LR   = 4'd1,
    AMO_SC   = 4'd2,
    AMO_SWAP = 4'd3,
    AMO_ADD  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_XOR  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MAXU = 4'd9,
    AMO_MIN  = 4'd10,
    AMO_MINU = 4'd11
  } amo_t;

  typedef enum logic [1:0] {
    ST_B = 2'd0,
    ST_H = 2'd1,
    ST_W = 2'd2,
    ST_D = 2'd3
  } st_size_e;

  typedef enum logic [1:0] {
    IDLE             = 2'd0,
    VALID            = 2'd1,
    WAIT_TRANSLATION = 2'd2,
    WAIT_READY       = 2'd3
  } st_state_e;

  localparam logic [5:0] ST_MISALIGNED_CAUSE = 6'd6;

  // Computed at 8 lanes; a 32-bit datapath uses the low 4.
  function automatic logic [7:0] be_gen(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic [7:0] m;
    unique case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // Rotate left by off bytes within the active XLEN.
  function automatic logic [63:0] data_rotate(
    input logic [63:0] data,
    input logic [2:0]  off,
    input logic        x32
  );
    logic [63:0] r;
    logic [5:0]  s32;
    logic [6:0]  s64;
    s32 = {1'b0, off[1:0], 3'b000};
    s64 = {1'b0, off, 3'b000};
    r = '0;
    if (x32) begin
      r[31:0] = (data[31:0] << s32) |
                (data[31:0] >> (6'd32 - s32));
    end else begin
      r = (data << s64) | (data >> (7'd64 - s64));
    end
    return r;
  endfunction

endpackage

// File: rtl/store_unit_gen_amo_queue.sv
// FIFO of AMO entries; flush drops all but the presented head.
// Ports: push/din/full in, valid/ready/dout out, flush_keep_head.
module store_unit_gen_amo_queue #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AMO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_keep_head,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] dout
);

  localparam int unsigned PW =
    (AMO_DEPTH > 1) ? $clog2(AMO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(AMO_DEPTH + 1);

  logic [DW-1:0] mem_q [AMO_DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr;
  logic [CW-1:0] cnt_q;
  logic          pop;
  logic          push_ok;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input logic [CW-1:0] n
  );
    int unsigned s;
    s = 32'(p) + 32'(n);
    if (s >= AMO_DEPTH) s = s - AMO_DEPTH;
    return PW'(s);
  endfunction

  assign valid   = cnt_q != '0;
  assign full    = cnt_q == CW'(AMO_DEPTH);
  assign pop     = valid && ready;
  // A full queue still takes a push when its head leaves.
  assign push_ok = push && !flush_keep_head &&
                   (!full || pop);
  assign wr      = wrap(rd_q, cnt_q);
  assign dout    = valid ? mem_q[rd_q] : '0;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr] <= din;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (pop) rd_q <= wrap(rd_q, CW'(1));
      if (flush_keep_head) begin
        cnt_q <= (valid && !pop) ? CW'(1) : '0;
      end else begin
        cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
      end
    end
  end

endmodule

// File: rtl/store_unit_gen.sv
// Store/AMO front end: translate, align, hand off to SB or AMO queue.
// Ports: request/pop, tlb req/resp, sb and amo handshakes, writeback.
module store_unit_gen
  import store_unit_gen_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned VLEN          = 39,
  parameter int unsigned PLEN          = 56,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned AMO_DEPTH     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [1:0]               size_i,
  input  logic                     is_amo_i,
  input  logic [3:0]               amo_op_i,
  input  logic [VLEN-1:0]          vaddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     pop_o,
  output logic                     translation_req_o,
  output logic [VLEN-1:0]          vaddr_o,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     tlb_hit_i,
  input  logic                     tlb_ex_valid_i,
  input  logic [5:0]               tlb_ex_cause_i,
  output logic                     sb_valid_o,
  input  logic                     sb_ready_i,
  output logic [PLEN-1:0]          sb_paddr_o,
  output logic [XLEN-1:0]          sb_data_o,
  output logic [XLEN/8-1:0]        sb_be_o,
  output logic [1:0]               sb_size_o,
  output logic                     amo_valid_o,
  input  logic                     amo_ready_i,
  output logic [3:0]               amo_op_o,
  output logic [PLEN-1:0]          amo_paddr_o,
  output logic [XLEN-1:0]          amo_data_o,
  output logic [1:0]               amo_size_o,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     ex_valid_o,
  output logic [5:0]               ex_cause_o,
  output logic [VLEN-1:0]          ex_tval_o
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned QW   = 4 + PLEN + XLEN + 2;

  typedef struct packed {
    logic                     ex;
    logic [5:0]               cause;
    logic [VLEN-1:0]          tval;
    logic                     amo;
    logic [3:0]               op;
    logic [PLEN-1:0]          paddr;
    logic [XLEN-1:0]          data;
    logic [NB-1:0]            be;
    logic [1:0]               size;
    logic [TRANS_ID_BITS-1:0] id;
  } s1_t;

  st_state_e     state_q, state_d;
  s1_t           s1_q, s1_d;
  logic          s1_full;
  logic          drain;
  logic          push;
  logic          can_acc;
  logic          load;
  logic          mis;
  logic          q_full;
  logic          q_can_push;
  logic [2:0]    off;
  logic [7:0]    be8;
  logic [63:0]   rot;
  logic [QW-1:0] q_din;
  logic [QW-1:0] q_dout;

  assign vaddr_o = vaddr_i;
  assign off     = 3'(vaddr_i[OFFW-1:0]);
  assign be8     = be_gen(size_i, off);
  assign rot     = data_rotate(64'(data_i), off,
                               XLEN == 32);

  always_comb begin
    mis = 1'b0;
    unique case (size_i)
      2'd0: mis = 1'b0;
      2'd1: mis = vaddr_i[0];
      2'd2: mis = |vaddr_i[1:0];
      // Doublewords do not exist on a 32-bit datapath.
      default: mis = (XLEN == 32) || (|vaddr_i[2:0]);
    endcase
  end

  assign s1_full = (state_q == VALID) ||
                   (state_q == WAIT_READY);
  assign q_can_push = !q_full ||
                      (amo_valid_o && amo_ready_i);

  always_comb begin
    drain      = 1'b0;
    push       = 1'b0;
    sb_valid_o = 1'b0;
    if (s1_full && !flush_i) begin
      unique case (1'b1)
        s1_q.ex:  drain = 1'b1;
        s1_q.amo: begin
          push  = q_can_push;
          drain = q_can_push;
        end
        default: begin
          sb_valid_o = 1'b1;
          drain      = sb_ready_i;
        end
      endcase
    end
  end

  always_comb begin
    can_acc = valid_i && !flush_i &&
              (!s1_full || drain);
    load    = can_acc &&
              (mis || tlb_ex_valid_i || tlb_hit_i);
    translation_req_o = can_acc;
    pop_o             = load;
    valid_o           = drain;
    ex_valid_o        = drain && s1_q.ex;

    state_d = IDLE;
    if (flush_i)                 state_d = IDLE;
    else if (load)               state_d = VALID;
    else if (can_acc)            state_d = WAIT_TRANSLATION;
    else if (s1_full && !drain)  state_d = WAIT_READY;
    else                         state_d = IDLE;

    s1_d = s1_q;
    if (load) begin
      s1_d.ex    = mis || tlb_ex_valid_i;
      s1_d.cause = mis ? ST_MISALIGNED_CAUSE
                       : tlb_ex_cause_i;
      s1_d.tval  = vaddr_i;
      s1_d.amo   = is_amo_i && !(mis || tlb_ex_valid_i);
      s1_d.op    = amo_op_i;
      s1_d.paddr = paddr_i;
      s1_d.data  = is_amo_i ? data_i : rot[XLEN-1:0];
      s1_d.be    = be8[NB-1:0];
      s1_d.size  = size_i;
      s1_d.id    = trans_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
    end
  end

  assign sb_paddr_o = s1_q.paddr;
  assign sb_data_o  = s1_q.data;
  assign sb_be_o    = s1_q.be;
  assign sb_size_o  = s1_q.size;
  assign trans_id_o = s1_q.id;
  assign ex_cause_o = s1_q.cause;
  assign ex_tval_o  = s1_q.tval;

  assign q_din = {s1_q.op, s1_q.paddr,
                  s1_q.data, s1_q.size};
  assign {amo_op_o, amo_paddr_o,
          amo_data_o, amo_size_o} = q_dout;

  store_unit_gen_amo_queue #(
    .DW        (QW),
    .AMO_DEPTH (AMO_DEPTH)
  ) u_amo_queue (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_keep_head (flush_i),
    .push            (push),
    .din             (q_din),
    .full            (q_full),
    .valid           (amo_valid_o),
    .ready           (amo_ready_i),
    .dout            (q_dout)
  );

endmodule

// File: tb/tb_store_unit_gen.sv
// Scoreboard bench for store_unit_gen (XLEN=64, AMO_DEPTH=2).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_store_unit_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic [1:0]  size_i;
  logic        is_amo_i;
  logic [3:0]  amo_op_i;
  logic [38:0] vaddr_i;
  logic [63:0] data_i;
  logic [2:0]  trans_id_i;
  logic        pop_o;
  logic        translation_req_o;
  logic [38:0] vaddr_o;
  logic [55:0] paddr_i;
  logic        tlb_hit_i;
  logic        tlb_ex_valid_i;
  logic [5:0]  tlb_ex_cause_i;
  logic        sb_valid_o;
  logic        sb_ready_i;
  logic [55:0] sb_paddr_o;
  logic [63:0] sb_data_o;
  logic [7:0]  sb_be_o;
  logic [1:0]  sb_size_o;
  logic        amo_valid_o;
  logic        amo_ready_i;
  logic [3:0]  amo_op_o;
  logic [55:0] amo_paddr_o;
  logic [63:0] amo_data_o;
  logic [1:0]  amo_size_o;
  logic        valid_o;
  logic [2:0]  trans_id_o;
  logic        ex_valid_o;
  logic [5:0]  ex_cause_o;
  logic [38:0] ex_tval_o;

  store_unit_gen #(
    .XLEN(64), .VLEN(39), .PLEN(56),
    .TRANS_ID_BITS(3), .AMO_DEPTH(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .size_i(size_i),
    .is_amo_i(is_amo_i), .amo_op_i(amo_op_i),
    .vaddr_i(vaddr_i), .data_i(data_i),
    .trans_id_i(trans_id_i), .pop_o(pop_o),
    .translation_req_o(translation_req_o),
    .vaddr_o(vaddr_o), .paddr_i(paddr_i),
    .tlb_hit_i(tlb_hit_i),
    .tlb_ex_valid_i(tlb_ex_valid_i),
    .tlb_ex_cause_i(tlb_ex_cause_i),
    .sb_valid_o(sb_valid_o), .sb_ready_i(sb_ready_i),
    .sb_paddr_o(sb_paddr_o), .sb_data_o(sb_data_o),
    .sb_be_o(sb_be_o), .sb_size_o(sb_size_o),
    .amo_valid_o(amo_valid_o),
    .amo_ready_i(amo_ready_i),
    .amo_op_o(amo_op_o), .amo_paddr_o(amo_paddr_o),
    .amo_data_o(amo_data_o), .amo_size_o(amo_size_o),
    .valid_o(valid_o), .trans_id_o(trans_id_o),
    .ex_valid_o(ex_valid_o), .ex_cause_o(ex_cause_o),
    .ex_tval_o(ex_tval_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  id;
    logic        ex;
    logic [5:0]  cause;
    logic [38:0] tval;
  } wb_t;
  typedef struct {
    logic [55:0] pa;
    logic [63:0] d;
    logic [7:0]  be;
  } sb_t;
  typedef struct {
    logic [3:0]  op;
    logic [55:0] pa;
    logic [63:0] d;
  } amo_e;

  wb_t  wbq[$];
  sb_t  sbq[$];
  amo_e amq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    valid_i = 0; tlb_hit_i = 0; tlb_ex_valid_i = 0;
    flush_i = 0; is_amo_i = 0;
  endtask

  task automatic req(input logic [1:0] sz,
                     input logic [38:0] va,
                     input logic [63:0] d,
                     input logic amo,
                     input logic [3:0] op,
                     input logic [2:0] id,
                     input logic hit,
                     input logic [55:0] pa);
    valid_i = 1; size_i = sz; vaddr_i = va;
    data_i = d; is_amo_i = amo; amo_op_i = op;
    trans_id_i = id; tlb_hit_i = hit; paddr_i = pa;
    tlb_ex_valid_i = 0;
  endtask

  task automatic exp_wb(input logic [2:0] id,
                        input logic ex,
                        input logic [5:0] c,
                        input logic [38:0] t);
    wbq.push_back('{id, ex, c, t});
  endtask

  task automatic exp_sb(input logic [55:0] pa,
                        input logic [63:0] d,
                        input logic [7:0] be);
    sbq.push_back('{pa, d, be});
  endtask

  task automatic exp_amo(input logic [3:0] op,
                         input logic [55:0] pa,
                         input logic [63:0] d);
    amq.push_back('{op, pa, d});
  endtask

  always @(negedge clk_i) begin
    wb_t  w;
    sb_t  s;
    amo_e m;
    if (rst_ni) begin
      if (valid_o) begin
        if (wbq.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_extra: got id %0d want none",
                   trans_id_o);
        end else begin
          w = wbq.pop_front();
          chk("wb_id", 64'(trans_id_o), 64'(w.id));
          chk("wb_ex", 64'(ex_valid_o), 64'(w.ex));
          if (w.ex) begin
            chk("wb_cause", 64'(ex_cause_o), 64'(w.cause));
            chk("wb_tval", 64'(ex_tval_o), 64'(w.tval));
          end
        end
      end
      if (sb_valid_o && sb_ready_i) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_extra: got pa %h want none",
                   sb_paddr_o);
        end else begin
          s = sbq.pop_front();
          chk("sb_paddr", 64'(sb_paddr_o), 64'(s.pa));
          chk("sb_data", sb_data_o, s.d);
          chk("sb_be", 64'(sb_be_o), 64'(s.be));
        end
      end
      if (amo_valid_o && amo_ready_i) begin
        if (amq.size() == 0) begin
          total++; bad++;
          $display("FAIL amo_extra: got pa %h want none",
                   amo_paddr_o);
        end else begin
          m = amq.pop_front();
          chk("amo_op", 64'(amo_op_o), 64'(m.op));
          chk("amo_paddr", 64'(amo_paddr_o), 64'(m.pa));
          chk("amo_data", amo_data_o, m.d);
        end
      end
    end
  end

  initial begin
    rst_ni = 0; idle_in();
    size_i = 0; vaddr_i = '0; data_i = '0;
    amo_op_i = 0; trans_id_i = 0; paddr_i = '0;
    tlb_ex_cause_i = 0; sb_ready_i = 1; amo_ready_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_sb_valid", 64'(sb_valid_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_amo_valid", 64'(amo_valid_o), 64'd0);
    chk("rst_paddr", 64'(sb_paddr_o), 64'd0);
    #2 rst_ni = 1;

    // 1: aligned SD with immediate hit
    step();
    req(2'd3, 39'h1008, 64'h1122334455667788, 0, 4'd0,
        3'd1, 1, 56'h1008);
    exp_wb(3'd1, 0, 6'd0, 39'd0);
    exp_sb(56'h1008, 64'h1122334455667788, 8'hFF);
    #3 chk("t1_pop", 64'(pop_o), 64'd1);
    step(); idle_in();
    #3 chk("t1_valid", 64'(valid_o), 64'd1);

    // 2: SB at offset 3 with store buffer stalled
    step();
    sb_ready_i = 0;
    req(2'd0, 39'h1003, 64'hAB, 0, 4'd0,
        3'd2, 1, 56'h1003);
    exp_wb(3'd2, 0, 6'd0, 39'd0);
    exp_sb(56'h1003, 64'h00000000AB000000, 8'h08);
    #3 chk("t2_pop", 64'(pop_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      req(2'd3, 39'h2000, 64'h0102030405060708, 0,
          4'd0, 3'd3, 1, 56'h2000);
      #3 chk("t2_stall_pop", 64'(pop_o), 64'd0);
      chk("t2_stall_valid", 64'(valid_o), 64'd0);
      chk("t2_sb_valid", 64'(sb_valid_o), 64'd1);
    end
    step();
    sb_ready_i = 1;
    exp_wb(3'd3, 0, 6'd0, 39'd0);
    exp_sb(56'h2000, 64'h0102030405060708, 8'hFF);
    #3 chk("t2_rdy_valid", 64'(valid_o), 64'd1);
    chk("t2_rdy_pop", 64'(pop_o), 64'd1);
    step(); idle_in();
    #3 chk("t2_next_valid", 64'(valid_o), 64'd1);

    // 3: misaligned SW
    step();
    req(2'd2, 39'h1002, 64'h55, 0, 4'd0, 3'd4, 0, 56'h0);
    exp_wb(3'd4, 1, 6'd6, 39'h1002);
    #3 chk("t3_pop", 64'(pop_o), 64'd1);
    step(); idle_in();
    #3 chk("t3_no_sb", 64'(sb_valid_o), 64'd0);
    chk("t3_valid", 64'(valid_o), 64'd1);

    // 4: four TLB misses then a hit
    step();
    req(2'd3, 39'h3000, 64'h77, 0, 4'd0, 3'd5, 0, 56'h0);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      #3 chk("t4_miss_treq", 64'(translation_req_o), 64'd1);
      chk("t4_miss_pop", 64'(pop_o), 64'd0);
    end
    step();
    tlb_hit_i = 1; paddr_i = 56'h8000_3000;
    exp_wb(3'd5, 0, 6'd0, 39'd0);
    exp_sb(56'h8000_3000, 64'h77, 8'hFF);
    #3 chk("t4_hit_treq", 64'(translation_req_o), 64'd1);
    chk("t4_hit_pop", 64'(pop_o), 64'd1);
    step(); idle_in();
    #3 chk("t4_valid", 64'(valid_o), 64'd1);
    step();
    #3 chk("t4_once", 64'(valid_o), 64'd0);

    // TLB exception
    step();
    req(2'd3, 39'h4000, 64'h0, 0, 4'd0, 3'd6, 0, 56'h0);
    tlb_ex_valid_i = 1; tlb_ex_cause_i = 6'd13;
    exp_wb(3'd6, 1, 6'd13, 39'h4000);
    #3 chk("tex_pop", 64'(pop_o), 64'd1);
    step(); idle_in();
    #3 chk("tex_valid", 64'(valid_o), 64'd1);

    // 5: three AMOADD.D into a depth-2 queue
    step();
    req(2'd3, 39'h5000, 64'h10, 1, 4'd4, 3'd1, 1,
        56'h5000);
    exp_wb(3'd1, 0, 6'd0, 39'd0);
    exp_amo(4'd4, 56'h5000, 64'h10);
    #3 chk("t5_pop_a", 64'(pop_o), 64'd1);
    step();
    req(2'd3, 39'h5008, 64'h20, 1, 4'd4, 3'd2, 1,
        56'h5008);
    exp_wb(3'd2, 0, 6'd0, 39'd0);
    exp_amo(4'd4, 56'h5008, 64'h20);
    #3 chk("t5_pop_b", 64'(pop_o), 64'd1);
    step();
    req(2'd3, 39'h5010, 64'h30, 1, 4'd4, 3'd3, 1,
        56'h5010);
    exp_wb(3'd3, 0, 6'd0, 39'd0);
    exp_amo(4'd4, 56'h5010, 64'h30);
    #3 chk("t5_pop_c", 64'(pop_o), 64'd1);
    step(); idle_in();
    #3 chk("t5_stall", 64'(valid_o), 64'd0);
    chk("t5_amo_valid", 64'(amo_valid_o), 64'd1);
    step();
    #3 chk("t5_stall2", 64'(valid_o), 64'd0);
    step();
    amo_ready_i = 1;
    #3 chk("t5_drain_c", 64'(valid_o), 64'd1);
    step(); step(); step();
    amo_ready_i = 0;
    #3 chk("t5_empty", 64'(amo_valid_o), 64'd0);

    // 6: flush with S1 full and two queued AMOs
    step();
    req(2'd2, 39'h6004, 64'hCAFE0000DEADBEEF, 1, 4'd3,
        3'd1, 1, 56'h6004);
    exp_wb(3'd1, 0, 6'd0, 39'd0);
    exp_amo(4'd3, 56'h6004, 64'hCAFE0000DEADBEEF);
    step();
    req(2'd3, 39'h6010, 64'h2, 1, 4'd3, 3'd2, 1,
        56'h6010);
    exp_wb(3'd2, 0, 6'd0, 39'd0);
    step();
    req(2'd3, 39'h6018, 64'h3, 1, 4'd3, 3'd3, 1,
        56'h6018);
    step(); idle_in();
    #3 chk("t6_full", 64'(valid_o), 64'd0);
    step();
    flush_i = 1;
    #3 chk("t6_fl_valid", 64'(valid_o), 64'd0);
    chk("t6_fl_head", 64'(amo_valid_o), 64'd1);
    step();
    flush_i = 0;
    #3 chk("t6_head", 64'(amo_valid_o), 64'd1);
    chk("t6_no_wb", 64'(valid_o), 64'd0);
    step();
    amo_ready_i = 1;
    step();
    amo_ready_i = 0;
    #3 chk("t6_dropped", 64'(amo_valid_o), 64'd0);
    req(2'd3, 39'h7000, 64'h99, 0, 4'd0, 3'd7, 1,
        56'h7000);
    exp_wb(3'd7, 0, 6'd0, 39'd0);
    exp_sb(56'h7000, 64'h99, 8'hFF);
    #1 chk("t6_idle_pop", 64'(pop_o), 64'd1);
    step(); idle_in();
    #3 chk("t6_valid", 64'(valid_o), 64'd1);

    repeat (3) step();
    chk("wbq_empty", 64'(wbq.size()), 64'd0);
    chk("sbq_empty", 64'(sbq.size()), 64'd0);
    chk("amq_empty", 64'(amq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_unit_gen.md
Name: store_unit_gen

Overview:
Parametrised next-generation store/AMO front end for the LSU. It requests address translation and checks alignment. It byte-aligns store data and generates byte enables for XLEN 32 or 64. It hands translated stores to the store buffer and AMOs to an internal AMO queue of configurable depth, which allows back-to-back AMOs. A single-entry translated stage (S1) decouples translation from the downstream valid/ready handshakes.

Parameters:
XLEN, 64, data width; only 32 or 64 are legal.
VLEN, 39, virtual address width.
PLEN, 56, physical address width.
TRANS_ID_BITS, 3, scoreboard transaction id width.
AMO_DEPTH, 2, AMO queue entries; legal range 1..4.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  pipeline flush
valid_i  in  1  store/AMO request present
size_i  in  2  0=B, 1=H, 2=W, 3=D (3 is illegal when XLEN=32)
is_amo_i  in  1  request is an AMO
amo_op_i  in  4  AMO encoding (amo_t)
vaddr_i  in  VLEN  virtual address
data_i  in  XLEN  unaligned store data
trans_id_i  in  TRANS_ID_BITS  id
pop_o  out  1  request consumed this cycle
translation_req_o  out  1  translation request
vaddr_o  out  VLEN  equals vaddr_i
paddr_i  in  PLEN  translated address, valid with tlb_hit_i
tlb_hit_i  in  1  translation hit
tlb_ex_valid_i  in  1  translation exception
tlb_ex_cause_i  in  6  exception cause
sb_valid_o  out  1  store to store buffer
sb_ready_i  in  1  store buffer accepts
sb_paddr_o  out  PLEN  store address
sb_data_o  out  XLEN  aligned data
sb_be_o  out  XLEN/8  byte enables
sb_size_o  out  2  size
amo_valid_o  out  1  AMO queue head valid
amo_ready_i  in  1  cache accepts AMO
amo_op_o  out  4  AMO op
amo_paddr_o  out  PLEN  AMO address
amo_data_o  out  XLEN  unshifted AMO data
amo_size_o  out  2  size
valid_o  out  1  writeback valid
trans_id_o  out  TRANS_ID_BITS  writeback id
ex_valid_o  out  1  writeback carries exception
ex_cause_o  out  6  cause
ex_tval_o  out  VLEN  faulting vaddr

Behaviour:
- Reset: state IDLE, S1 empty, AMO queue empty; every output 0 except vaddr_o, which is combinational.
- Offset: off = vaddr_i[log2(XLEN/8)-1:0].
- Misaligned: the low size_i bits of vaddr_i are nonzero. Detected combinationally, before translation.
- Byte enables: ((1<<(1<<size))-1) << off.
- Store data: rotated left by off*8 bits. AMO data is not shifted.
- FSM states are IDLE, VALID, WAIT_TRANSLATION and WAIT_READY. VALID means S1 is full.
- Accept condition (issue cycle): valid_i and no flush_i and (S1 empty or S1 drains this cycle).
  - On accept, translation_req_o=1.
  - misaligned: pop_o=1. S1 is loaded as an exception with cause 6 and tval=vaddr_i. No translation result is needed.
  - tlb_ex_valid_i: pop_o=1. S1 is loaded as an exception with tlb_ex_cause_i.
  - tlb_hit_i: pop_o=1. S1 is loaded with paddr, data, be, size, op and id.
  - Otherwise: pop_o=0 and the next state is WAIT_TRANSLATION. translation_req_o is held high each cycle until a hit or exception, at which point pop_o=1 and S1 loads.
- Drain from S1:
  - Exception entry: valid_o=1 with ex fields, no push, drains unconditionally.
  - Store: sb_valid_o=1. Drains when sb_ready_i; valid_o=1 in the same cycle.
  - AMO: pushes into the AMO queue. Drains when the queue is not full; valid_o=1 in the same cycle.
  - Not drained: the state is WAIT_READY, S1 holds, and no new accept occurs.
- valid_o fires exactly once per popped request, on the S1 drain cycle. Minimum latency is one cycle after pop; throughput is 1 per cycle.
- AMO queue: FIFO of AMO_DEPTH entries. amo_valid_o is asserted when the queue is non-empty, and the head pops on amo_ready_i.
  - A simultaneous push and pop while full is allowed.
  - The pointers wrap modulo AMO_DEPTH.
  - Output fields must be stable while amo_valid_o=1 and amo_ready_i=0.
- flush_i:
  - S1 is discarded with no sb push, no AMO push and no valid_o. State returns to IDLE. No accept occurs that cycle.
  - Queued AMOs that are not at the head are dropped. A head already presented with amo_valid_o stays until its handshake.
- sb_valid_o is never asserted for AMO or exception entries; amo pushes are never made for plain stores.

Decomposition:
- Package additions: amo_t (existing); st_size_e; the constant ST_MISALIGNED_CAUSE=6; the functions be_gen(size,off) and data_rotate(data,off), parametrised on XLEN.
- One sub-module, amo_queue (generic FIFO of amo entries, parameter AMO_DEPTH, with a keep_head flush input).

Test Plan:
1. XLEN=64: SD at 0x1008 with data 0x1122334455667788 and an immediate hit -> pop same cycle. Next cycle: sb_valid_o=1, be=0xFF, paddr=0x1008, valid_o=1.
2. SB at vaddr 0x1003 with data 0xAB and sb_ready_i low for 3 cycles -> be=0x08, sb_data_o[31:24]=0xAB, valid_o deferred until the ready cycle, next valid_i not popped meanwhile.
3. SW at 0x1002 -> pop_o=1, no sb_valid_o; next cycle valid_o=1, ex_valid_o=1, cause=6, tval=0x1002.
4. TLB miss for 4 cycles, then hit -> translation_req_o held high for 5 cycles, pop_o only on the hit cycle, one valid_o.
5. AMO_DEPTH=2: three AMOADD.D back-to-back with amo_ready_i=0 -> two queued, the third stalls in S1 with valid_o withheld. One amo_ready_i pulse -> the third drains.
6. Flush with S1 full and 2 AMOs queued, head presented -> no valid_o, the head remains until amo_ready_i, the second AMO is dropped, state IDLE.
